cpu_sysif: RTL
==============

# cpu_sysif

System-interface controller for the MCS8 (Intel 8008) core. It sits directly downstream of `cpu`, decoding its `STATE_O`/`SYNC_O` and multiplexed 8-bit bus into a 14-bit address, cycle type and discrete memory/IO strobes. It also returns read data and `READY` to the core, and jams an `RST` opcode during interrupt acknowledge. One instance per CPU, between `cpu` and the memory/IO fabric.

## Interface
Parameters:
- `IO_IN_PORTS`, default 8. Port numbers below this value are inputs (INP); the rest are outputs (OUT).
- `RST_OPC_LOW`, default 3'b101. Low opcode bits used to form the jammed `RST` instruction.

Ports:
- `CLK_I`  in  1  single system clock, same clock that drives the core's `CLK2_I`.
- `RST_I`  in  1  reset, synchronous, active-high.
- `SYNC_I`  in  1  core `SYNC_O`. Toggles each clock, so one CPU state spans two clocks.
- `STATE_I`  in  3  core `STATE_O` encoding: T1=010, T2=100, T3=001, T4=111, T5=101, T1I=110, STOP=011, WAIT=000.
- `CPU_DAT_I`  in  8  core `DAT_O` (address or write data).
- `CPU_DAT_O`  out  8  data to core `DAT_I`.
- `CPU_READY_O`  out  1  to core `READY_I`.
- `ADDR_O`  out  14  latched memory address.
- `PORT_O`  out  5  IO port number.
- `CYC_O`  out  2  cycle type: 00 PCI, 01 PCC, 10 PCR, 11 PCW.
- `MEM_RD_O`, `MEM_WR_O`, `IO_RD_O`, `IO_WR_O`  out  1 each  access strobes.
- `WR_DAT_O`  out  8  data for a memory or IO write.
- `RD_DAT_I`  in  8  memory or IO read data.
- `RDY_I`  in  1  fabric access complete.
- `INT_VEC_I`  in  3  interrupt restart vector.
- `INTA_O`  out  1  interrupt acknowledge in progress.
- `HALT_O`  out  1  core is in STOP.

## Operation
- **State strobe.** A state is valid on the clock edge where `SYNC_I`=1. All decoding uses `st_stb = SYNC_I`. `STATE_I` is registered at the strobe.
- **FSM states.** IDLE, ADDR_L, ADDR_H, ACCESS, HOLD.
- **T1 / T1I strobe** → ADDR_L.
  - `addr_lo` <= `CPU_DAT_I`.
  - For T1I, set `inta`.
- **T2 strobe** → ADDR_H.
  - `ADDR_O[13:8]` <= `CPU_DAT_I[5:0]`.
  - `CYC_O` <= `CPU_DAT_I[7:6]`.
  - `ADDR_O[7:0]` <= `addr_lo`.
  - For PCC: `PORT_O` <= `CPU_DAT_I[5:1]` and `WR_DAT_O` <= `addr_lo` (the accumulator).
- **T3 or WAIT strobe** → ACCESS. Strobe by cycle type:
  - PCI/PCR: `MEM_RD_O`. If `inta`, no memory read is issued.
  - PCW: `MEM_WR_O`, with `WR_DAT_O` <= `CPU_DAT_I` taken at the T3 strobe. Memory address and data are stable throughout.
  - PCC with `PORT_O < IO_IN_PORTS`: `IO_RD_O`.
  - PCC otherwise: `IO_WR_O`.
- **Completion.** When `RDY_I`=1 (or immediately, see Configuration), capture `RD_DAT_I` into `CPU_DAT_O`, drop the strobes and go to HOLD.
- **Interrupt acknowledge.** When `inta` and PCI, `CPU_DAT_O` = {2'b00, `INT_VEC_I`, `RST_OPC_LOW`}. `INTA_O` is high from the T1I strobe to the end of T3. `inta` clears at the next T1.
- **HOLD.** `CPU_DAT_O` is held until the next T1/T1I strobe, then returns to ADDR_L.
- **T4/T5** → IDLE. No external activity.
- **STOP.** `HALT_O`=1 while `STATE_I`==STOP. It clears on any other state.
- **Reset values.** Address, port, data and `CYC_O` outputs = 0. All strobes = 0. `INTA_O`=0, `HALT_O`=0. `CPU_READY_O`=1. FSM=IDLE. `RST_I` mid-access aborts the strobe on the same edge.

## Timing
- Outputs are registered, with 1-clock latency from the strobe edge.
- `ADDR_O`/`CYC_O` are valid from the clock after the T2 strobe until the next T2 strobe.
- `CPU_READY_O` drops on the clock after T2 if the pending access is not yet complete. It rises on the clock after `RDY_I`. The core then re-enters T3 from WAIT.
- Read data reaches `CPU_DAT_O` at least one clock before the T3 strobe on which the core latches it.
- Strobes never overlap. A new T1 while in ACCESS (protocol violation) forces the strobes low and restarts at ADDR_L.

## Configuration
- `MCS8_SYSIF_WAIT_EN` defined:
  - `RDY_I` is honoured and `CPU_READY_O` is generated as above.
  - A 4-bit wait counter is compiled in. It counts clocks in ACCESS and saturates at 15; its value is for debug only.
- Undefined:
  - `RDY_I` is ignored and `CPU_READY_O` is constant 1.
  - Every access completes in the first ACCESS clock.

## Structure
- Shared package `mcs8_pkg`: cycle-type constants (PCI/PCC/PCR/PCW), the STATE_I encodings, and the FSM state enum.
- One sub-module, `cpu_sysif_latch`: the T1/T2 address and cycle-type latch.
- FSM and strobe generation live in `cpu_sysif`.

## Test plan
- **Fetch.** T1 `CPU_DAT_I`=0x34, T2=0x12 (PCI), `RDY_I` tied 1, `RD_DAT_I`=0xC0 → `ADDR_O`=0x1234, `CYC_O`=00, one `MEM_RD_O` pulse, `CPU_DAT_O`=0xC0 before the T3 strobe.
- **Memory write.** T2=0xC5 (PCW, A13:8=0x05), T3 data 0xA5 → `ADDR_O`=0x05xx, `MEM_WR_O` with `WR_DAT_O`=0xA5.
- **Wait states** (`WAIT_EN`). `RDY_I` held low 5 clocks → `CPU_READY_O`=0 during that time, the core shows WAIT, the strobe stays high, and it releases one clock after `RDY_I`.
- **IO.** PCC with T2=0x46 (port 3) and T1=0x77 → `IO_RD_O`. PCC with T2=0x52 (port 9) → `IO_WR_O`, `WR_DAT_O`=0x77.
- **Interrupt.** T1I with `INT_VEC_I`=3'b111 → `INTA_O`=1, no `MEM_RD_O`, `CPU_DAT_O`=0x3D.
- **Reset and halt.** `RST_I` asserted during ACCESS → strobes 0 next edge, `CPU_READY_O`=1. STOP state → `HALT_O`=1; next T1 → `HALT_O`=0.

Source files
------------

// File: rtl/mcs8_pkg.sv
// Shared MCS8 definitions: bus cycle types, core STATE_O encodings and the
// system-interface FSM state enum.
package mcs8_pkg;

  localparam logic [1:0] CYC_PCI = 2'b00;
  localparam logic [1:0] CYC_PCC = 2'b01;
  localparam logic [1:0] CYC_PCR = 2'b10;
  localparam logic [1:0] CYC_PCW = 2'b11;

  localparam logic [2:0] ST_T1   = 3'b010;
  localparam logic [2:0] ST_T2   = 3'b100;
  localparam logic [2:0] ST_T3   = 3'b001;
  localparam logic [2:0] ST_T4   = 3'b111;
  localparam logic [2:0] ST_T5   = 3'b101;
  localparam logic [2:0] ST_T1I  = 3'b110;
  localparam logic [2:0] ST_STOP = 3'b011;
  localparam logic [2:0] ST_WAIT = 3'b000;

  typedef enum logic [2:0] {
    SIF_IDLE   = 3'd0,
    SIF_ADDR_L = 3'd1,
    SIF_ADDR_H = 3'd2,
    SIF_ACCESS = 3'd3,
    SIF_HOLD   = 3'd4
  } sifState_e;

  function automatic logic isT1State(input logic [2:0] st);
    return (st == ST_T1) || (st == ST_T1I);
  endfunction

endpackage

// File: rtl/cpu_sysif_latch.sv
// T1/T2 address latch: low byte at T1, high bits, cycle type and IO port at T2.
module cpu_sysif_latch
  import mcs8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        loadLo,
  input  logic        loadHi,
  input  logic [7:0]  dat,
  output logic [7:0]  addrLo,
  output logic [13:0] addr,
  output logic [1:0]  cyc,
  output logic [4:0]  port
);

  // Capture the multiplexed address bytes as the core presents them.
  always_ff @(posedge clk) begin
    if (rst) begin
      addrLo <= 8'h00;
      addr   <= 14'h0000;
      cyc    <= 2'b00;
      port   <= 5'h00;
    end else begin
      if (loadLo) begin
        addrLo <= dat;
      end
      if (loadHi) begin
        addr <= {dat[5:0], addrLo};
        cyc  <= dat[7:6];
        if (dat[7:6] == CYC_PCC) begin
          port <= dat[5:1];
        end
      end
    end
  end

endmodule

// File: rtl/cpu_sysif.sv
// MCS8 system-interface controller: decodes core states into address, cycle
// type and memory/IO strobes. Define MCS8_SYSIF_WAIT_EN to honour RDY_I.
module cpu_sysif
  import mcs8_pkg::*;
#(
  parameter int         IO_IN_PORTS = 8,
  parameter logic [2:0] RST_OPC_LOW = 3'b101
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        SYNC_I,
  input  logic [2:0]  STATE_I,
  input  logic [7:0]  CPU_DAT_I,
  output logic [7:0]  CPU_DAT_O,
  output logic        CPU_READY_O,
  output logic [13:0] ADDR_O,
  output logic [4:0]  PORT_O,
  output logic [1:0]  CYC_O,
  output logic        MEM_RD_O,
  output logic        MEM_WR_O,
  output logic        IO_RD_O,
  output logic        IO_WR_O,
  output logic [7:0]  WR_DAT_O,
  input  logic [7:0]  RD_DAT_I,
  input  logic        RDY_I,
  input  logic [2:0]  INT_VEC_I,
  output logic        INTA_O,
  output logic        HALT_O
);

  logic       stStb;
  logic       isT1;
  logic       isT2;
  logic       isT3w;
  logic       isT45;
  logic       ioIn;
  logic       accDone;
  logic       intaR;
  logic [7:0] addrLo;
  sifState_e  fsmR;

  assign stStb = SYNC_I;
  assign isT1  = stStb && isT1State(STATE_I);
  assign isT2  = stStb && (STATE_I == ST_T2);
  assign isT3w = stStb && ((STATE_I == ST_T3) || (STATE_I == ST_WAIT));
  assign isT45 = stStb && ((STATE_I == ST_T4) || (STATE_I == ST_T5));
  assign ioIn  = (32'(PORT_O) < 32'(IO_IN_PORTS));

`ifdef MCS8_SYSIF_WAIT_EN
  logic       readyR;
  logic [3:0] waitCnt;
  // The acknowledge cycle has no fabric access, so it never waits.
  assign accDone     = RDY_I || (intaR && (CYC_O == CYC_PCI));
  assign CPU_READY_O = readyR;

  // Saturating count of clocks spent in ACCESS, for debug visibility.
  always_ff @(posedge CLK_I) begin
    if (RST_I || (fsmR != SIF_ACCESS)) begin
      waitCnt <= 4'd0;
    end else if (waitCnt != 4'd15) begin
      waitCnt <= waitCnt + 4'd1;
    end
  end
`else
  logic unusedRdy;
  assign unusedRdy   = RDY_I;
  assign accDone     = 1'b1;
  assign CPU_READY_O = 1'b1;
`endif

  cpu_sysif_latch uLatch (
    .clk    (CLK_I),
    .rst    (RST_I),
    .loadLo (isT1),
    .loadHi (isT2),
    .dat    (CPU_DAT_I),
    .addrLo (addrLo),
    .addr   (ADDR_O),
    .cyc    (CYC_O),
    .port   (PORT_O)
  );

  // Bus-cycle FSM with registered strobes, read data and acknowledge flag.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      fsmR      <= SIF_IDLE;
      intaR     <= 1'b0;
      INTA_O    <= 1'b0;
      MEM_RD_O  <= 1'b0;
      MEM_WR_O  <= 1'b0;
      IO_RD_O   <= 1'b0;
      IO_WR_O   <= 1'b0;
      CPU_DAT_O <= 8'h00;
      WR_DAT_O  <= 8'h00;
`ifdef MCS8_SYSIF_WAIT_EN
      readyR    <= 1'b1;
`endif
    end else if (isT1) begin
      // A new T1 also recovers from a T1 arriving mid-access.
      fsmR     <= SIF_ADDR_L;
      intaR    <= (STATE_I == ST_T1I);
      INTA_O   <= (STATE_I == ST_T1I);
      MEM_RD_O <= 1'b0;
      MEM_WR_O <= 1'b0;
      IO_RD_O  <= 1'b0;
      IO_WR_O  <= 1'b0;
`ifdef MCS8_SYSIF_WAIT_EN
      readyR   <= 1'b1;
`endif
    end else if ((fsmR == SIF_ACCESS) && accDone) begin
      fsmR      <= SIF_HOLD;
      INTA_O    <= 1'b0;
      MEM_RD_O  <= 1'b0;
      MEM_WR_O  <= 1'b0;
      IO_RD_O   <= 1'b0;
      IO_WR_O   <= 1'b0;
      CPU_DAT_O <= (intaR && (CYC_O == CYC_PCI)) ?
                   {2'b00, INT_VEC_I, RST_OPC_LOW} : RD_DAT_I;
`ifdef MCS8_SYSIF_WAIT_EN
      readyR    <= 1'b1;
`endif
    end else if (isT2) begin
      fsmR <= SIF_ADDR_H;
      // For IO the accumulator travels in the T1 byte.
      if (CPU_DAT_I[7:6] == CYC_PCC) begin
        WR_DAT_O <= addrLo;
      end
`ifdef MCS8_SYSIF_WAIT_EN
      readyR <= 1'b0;
`endif
    end else if (isT3w && (fsmR == SIF_ADDR_H)) begin
      fsmR <= SIF_ACCESS;
      case (CYC_O)
        CYC_PCI, CYC_PCR: MEM_RD_O <= ~intaR;
        CYC_PCW: begin
          MEM_WR_O <= 1'b1;
          WR_DAT_O <= CPU_DAT_I;
        end
        CYC_PCC: begin
          if (ioIn) begin
            IO_RD_O <= 1'b1;
          end else begin
            IO_WR_O <= 1'b1;
          end
        end
        default: fsmR <= SIF_ACCESS;
      endcase
    end else if (isT45 && (fsmR != SIF_ACCESS)) begin
      fsmR <= SIF_IDLE;
    end
  end

  // HALT follows the most recently strobed core state.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      HALT_O <= 1'b0;
    end else if (stStb) begin
      HALT_O <= (STATE_I == ST_STOP);
    end
  end

endmodule
